// File: rtl/fetch_stall_if.sv
// Fetch/decode boundary bundle for fetch_stall_controller.
// master: environment side (hazard unit, branch/jump resolution, instruction
//         memory data); slave: the fetch stall controller itself.
interface fetch_stall_if #(
  parameter int LEN_PC       = 32,
  parameter int LEN_INSTR    = 32,
  parameter int LEN_PERF_CNT = 16
);
  logic                    stall;
  logic                    branch_taken_id;
  logic [LEN_PC-1:0]       branch_target_id;
  logic                    jump_id;
  logic [LEN_PC-1:0]       jump_target_id;
  logic [LEN_INSTR-1:0]    instr_if;
  logic [LEN_PC-1:0]       pc_if;
  logic [LEN_INSTR-1:0]    instr_id;
  logic [LEN_PC-1:0]       pc_plus4_id;
  logic                    valid_id;
  logic                    bubble_ex;
  logic [LEN_PERF_CNT-1:0] stall_cycles;
  logic [LEN_PERF_CNT-1:0] flush_count;

  modport master (
    output stall, branch_taken_id, branch_target_id, jump_id, jump_target_id, instr_if,
    input  pc_if, instr_id, pc_plus4_id, valid_id, bubble_ex, stall_cycles, flush_count
  );

  modport slave (
    input  stall, branch_taken_id, branch_target_id, jump_id, jump_target_id, instr_if,
    output pc_if, instr_id, pc_plus4_id, valid_id, bubble_ex, stall_cycles, flush_count
  );
endinterface

// File: rtl/fetch_stall_controller.sv
// Fetch stall controller: owns the PC and the IF/ID register, freezes both on a
// hazard stall (injecting an ID/EX bubble) and loads branch/jump targets while
// squashing the wrong-path instruction.
// Optional feature macro: FETCH_PERF_COUNTERS_EN enables saturating stall-cycle
// and redirect counters; without it both counter outputs are constant zero.
module fetch_stall_controller #(
  parameter int              LEN_PC       = 32,
  parameter int              LEN_INSTR    = 32,
  parameter logic [LEN_PC-1:0] PC_RESET   = '0,
  parameter int              LEN_PERF_CNT = 16
) (
  input  logic       clk,
  input  logic       reset,
  fetch_stall_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t               state_r;
  logic [LEN_PC-1:0]    pc_r;
  logic [LEN_INSTR-1:0] instr_id_r;
  logic [LEN_PC-1:0]    pc_plus4_id_r;
  logic                 valid_id_r;

  logic [LEN_PC-1:0]    pc_plus4_s;
  logic [LEN_PC-1:0]    target_s;
  logic                 redirect_s;

  // Next sequential PC, redirect qualification and target selection (jump wins).
  always_comb begin
    pc_plus4_s = pc_r + LEN_PC'(32'd4);
    // A squashed slot cannot redirect; SQUASH always leaves IF/ID invalid.
    redirect_s = (bus.branch_taken_id | bus.jump_id) & valid_id_r & (state_r != SQUASH);
    if (bus.jump_id) begin
      target_s = bus.jump_target_id;
    end else begin
      target_s = bus.branch_target_id;
    end
  end

  // The bubble must reach ID/EX in the same cycle the hazard unit raises stall.
  assign bus.bubble_ex = bus.stall & ~reset;

  // Fetch FSM with PC and IF/ID registers: reset > stall > redirect > fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= RUN;
      pc_r          <= PC_RESET;
      instr_id_r    <= '0;
      pc_plus4_id_r <= '0;
      valid_id_r    <= 1'b0;
    end else if (bus.stall) begin
      state_r <= HOLD;
    end else if (redirect_s) begin
      state_r       <= SQUASH;
      pc_r          <= target_s;
      instr_id_r    <= '0;
      pc_plus4_id_r <= '0;
      valid_id_r    <= 1'b0;
    end else begin
      state_r       <= RUN;
      pc_r          <= pc_plus4_s;
      instr_id_r    <= bus.instr_if;
      pc_plus4_id_r <= pc_plus4_s;
      valid_id_r    <= 1'b1;
    end
  end

  assign bus.pc_if       = pc_r;
  assign bus.instr_id    = instr_id_r;
  assign bus.pc_plus4_id = pc_plus4_id_r;
  assign bus.valid_id    = valid_id_r;

`ifdef FETCH_PERF_COUNTERS_EN
  localparam logic [LEN_PERF_CNT-1:0] CNT_MAX = {LEN_PERF_CNT{1'b1}};

  logic [LEN_PERF_CNT-1:0] stall_cycles_r;
  logic [LEN_PERF_CNT-1:0] flush_count_r;

  // Saturating counters of stalled cycles and accepted redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_r <= '0;
      flush_count_r  <= '0;
    end else begin
      if (bus.stall && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + LEN_PERF_CNT'(32'd1);
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (!bus.stall && redirect_s && (flush_count_r != CNT_MAX)) begin
        flush_count_r <= flush_count_r + LEN_PERF_CNT'(32'd1);
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  assign bus.stall_cycles = stall_cycles_r;
  assign bus.flush_count  = flush_count_r;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_fetch_stall_controller.sv
// Directed, table-driven bench for fetch_stall_controller plus hand-written
// multi-cycle sequences (long stall, reset racing a redirect).
module tb_fetch_stall_controller;

`ifdef FETCH_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  fetch_stall_if #(.LEN_PC(32), .LEN_INSTR(32), .LEN_PERF_CNT(16)) bus ();

  fetch_stall_controller #(
    .LEN_PC(32), .LEN_INSTR(32), .PC_RESET(32'h0000_0000), .LEN_PERF_CNT(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] brt;
    logic        j;
    logic [31:0] jt;
    logic [31:0] instr;
    logic        e_bubble;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pp4;
    logic        e_valid;
    logic [15:0] e_sc;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic rst, logic stall, logic br, logic [31:0] brt,
                              logic j, logic [31:0] jt, logic [31:0] instr,
                              logic e_bubble, logic [31:0] e_pc, logic [31:0] e_instr,
                              logic [31:0] e_pp4, logic e_valid,
                              logic [15:0] e_sc, logic [15:0] e_fc);
    vec_t v;
    v.rst = rst; v.stall = stall; v.br = br; v.brt = brt; v.j = j; v.jt = jt;
    v.instr = instr; v.e_bubble = e_bubble; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_pp4 = e_pp4; v.e_valid = e_valid; v.e_sc = e_sc; v.e_fc = e_fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic br, input logic [31:0] brt,
                       input logic j, input logic [31:0] jt, input logic [31:0] instr);
    reset                = rst;
    bus.stall            = stall;
    bus.branch_taken_id  = br;
    bus.branch_target_id = brt;
    bus.jump_id          = j;
    bus.jump_target_id   = jt;
    bus.instr_if         = instr;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pp4, input logic e_valid,
                            input logic [15:0] e_sc, input logic [15:0] e_fc);
    check({tag, ".pc_if"},       bus.pc_if,       e_pc);
    check({tag, ".instr_id"},    bus.instr_id,    e_instr);
    check({tag, ".pc_plus4_id"}, bus.pc_plus4_id, e_pp4);
    check({tag, ".valid_id"},    {31'd0, bus.valid_id}, {31'd0, e_valid});
    check({tag, ".stall_cycles"}, {16'd0, bus.stall_cycles}, PERF ? {16'd0, e_sc} : 32'd0);
    check({tag, ".flush_count"},  {16'd0, bus.flush_count},  PERF ? {16'd0, e_fc} : 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

    //            rst   stl   br    brt           j     jt            instr          bub   pc            instr_id      pp4           vld   sc     fc
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h1111_1111, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 16'd0, 16'd0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h1111_1111, 1'b0, 32'h4,        32'h1111_1111, 32'h4,       1'b1, 16'd0, 16'd0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h1111_1111, 1'b0, 32'h8,        32'h1111_1111, 32'h8,       1'b1, 16'd0, 16'd0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h1111_1111, 1'b0, 32'hC,        32'h1111_1111, 32'hC,       1'b1, 16'd0, 16'd0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h2222_2222, 1'b0, 32'h10,       32'h2222_2222, 32'h10,      1'b1, 16'd0, 16'd0);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h3333_3333, 1'b1, 32'h10,       32'h2222_2222, 32'h10,      1'b1, 16'd1, 16'd0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h3333_3333, 1'b1, 32'h10,       32'h2222_2222, 32'h10,      1'b1, 16'd2, 16'd0);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h4444_4444, 1'b0, 32'h14,       32'h4444_4444, 32'h14,      1'b1, 16'd2, 16'd0);
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        32'h5555_5555, 1'b0, 32'h40,       32'h0,        32'h0,        1'b0, 16'd2, 16'd1);
    vecs[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h6666_6666, 1'b0, 32'h44,       32'h6666_6666, 32'h44,      1'b1, 16'd2, 16'd1);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 32'h80,       1'b0, 32'h0,        32'h7777_7777, 1'b1, 32'h44,       32'h6666_6666, 32'h44,      1'b1, 16'd3, 16'd1);
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 32'h80,       1'b0, 32'h0,        32'h7777_7777, 1'b0, 32'h80,       32'h0,        32'h0,        1'b0, 16'd3, 16'd2);
    vecs[12] = mk(1'b0, 1'b0, 1'b1, 32'h200,      1'b0, 32'h0,        32'h7777_7777, 1'b0, 32'h84,       32'h7777_7777, 32'h84,      1'b1, 16'd3, 16'd2);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 32'h40,       1'b1, 32'h100,      32'h7777_7777, 1'b0, 32'h100,      32'h0,        32'h0,        1'b0, 16'd3, 16'd3);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8888_8888, 1'b0, 32'h104,      32'h8888_8888, 32'h104,     1'b1, 16'd3, 16'd3);
    vecs[15] = mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8888_8888, 1'b1, 32'h104,      32'h8888_8888, 32'h104,     1'b1, 16'd4, 16'd3);
    vecs[16] = mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h8888_8888, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0, 16'd0, 16'd0);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h1234_5678, 1'b0, 32'h4,        32'h1234_5678, 32'h4,       1'b1, 16'd0, 16'd0);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 32'hFFFF_FFFC, 32'h0,      32'h0,        1'b0, 16'd0, 16'd1);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h9999_9999, 1'b0, 32'h0,        32'h9999_9999, 32'h0,       1'b1, 16'd0, 16'd1);
    vecs[20] = mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'hAAAA_AAAA, 1'b0, 32'h4,        32'hAAAA_AAAA, 32'h4,       1'b1, 16'd0, 16'd1);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].brt, vecs[i].j, vecs[i].jt, vecs[i].instr);
      #1;
      check($sformatf("v%0d.bubble_ex", i), {31'd0, bus.bubble_ex}, {31'd0, vecs[i].e_bubble});
      @(posedge clk);
      #1;
      check_regs($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pp4,
                 vecs[i].e_valid, vecs[i].e_sc, vecs[i].e_fc);
    end

    // Long stall from pc_if=4: everything frozen, bubble every cycle, no timeout.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'hBBBB_BBBB);
      #1;
      check($sformatf("long%0d.bubble_ex", k), {31'd0, bus.bubble_ex}, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("long%0d.pc_if", k), bus.pc_if, 32'h4);
      check($sformatf("long%0d.instr_id", k), bus.instr_id, 32'hAAAA_AAAA);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'hCCCC_CCCC);
    #1;
    check("long_rel.bubble_ex", {31'd0, bus.bubble_ex}, 32'd0);
    @(posedge clk);
    #1;
    check_regs("long_rel", 32'h8, 32'hCCCC_CCCC, 32'h8, 1'b1, 16'd12, 16'd1);

    // Reset wins over a simultaneous valid redirect.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 32'hDDDD_DDDD);
    @(posedge clk);
    #1;
    check_regs("rst_redir", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);

    // Right after reset valid_id=0, so a taken branch must be ignored.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 32'hEEEE_EEEE);
    @(posedge clk);
    #1;
    check_regs("post_rst_br", 32'h4, 32'hEEEE_EEEE, 32'h4, 1'b1, 16'd0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
